// File: rtl/spi_master_ram_ctrl_if.sv
// Host-side request/response and SPI pin bundle for the SPI RAM master.
// The master modport is the controller side. The slave modport is the host/pin side.
interface spi_master_ram_ctrl_if;
   logic       start;
   logic [1:0] cmd;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic [7:0] rdata;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;

   modport master (
      input  start, cmd, wdata, MISO,
      output busy, done, rdata, SS_n, MOSI
   );

   modport slave (
      output start, cmd, wdata, MISO,
      input  busy, done, rdata, SS_n, MOSI
   );
endinterface

// File: rtl/spi_master_ram_ctrl.sv
// SPI master that runs one 10-bit {cmd,data} frame per start request against a serial RAM.
// The master runs on clk_sys, which is also the bit clock. Read-data frames capture one byte after RD_LAT idle cycles.
//
// state   | meaning
// IDLE    | SS_n high, waiting for start
// SELECT  | SS_n low, MOSI = cmd[1] lead-in bit
// SHIFT   | 10 frame bits out on MOSI, MSB first
// WAIT    | read latency, RD_LAT cycles
// CAPTURE | 8 MISO bits in, MSB first
// GAP_ST  | SS_n high for GAP cycles, done on first cycle
module spi_master_ram_ctrl #(
   parameter int RD_LAT = 2,
   parameter int GAP    = 1
) (
   input logic                   clk,
   input logic                   rst,
   spi_master_ram_ctrl_if.master bus
);

   typedef enum logic [2:0] {IDLE, SELECT, SHIFT, WAIT, CAPTURE, GAP_ST} state_t;

   localparam logic [3:0] RD_LAT_TC = 4'(RD_LAT - 1);
   localparam logic [3:0] GAP_TC    = 4'(GAP - 1);

   state_t     state;
   logic [9:0] sreg;
   logic [7:0] cap;
   logic [3:0] cnt;
   logic       rd_frame;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         cap       <= '0;
         cnt       <= '0;
         rd_frame  <= 1'b0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.rdata <= '0;
         bus.SS_n  <= 1'b1;
         bus.MOSI  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sreg     <= {bus.cmd, bus.wdata};
                  rd_frame <= (bus.cmd == 2'b11);
                  bus.busy <= 1'b1;
                  bus.SS_n <= 1'b0;
                  bus.MOSI <= bus.cmd[1];
                  state    <= SELECT;
               end
            end
            SELECT: begin
               bus.MOSI <= sreg[9];
               cnt      <= 4'd9;
               state    <= SHIFT;
            end
            SHIFT: begin
               // cnt counts down from 9. Each cycle presents the next bit one cycle ahead of its slot.
               if (cnt == 4'd0) begin
                  bus.MOSI <= 1'b0;
                  if (rd_frame) begin
                     cnt   <= RD_LAT_TC;
                     state <= WAIT;
                  end else begin
                     bus.SS_n <= 1'b1;
                     bus.done <= 1'b1;
                     cnt      <= GAP_TC;
                     state    <= GAP_ST;
                  end
               end else begin
                  bus.MOSI <= sreg[8];
                  sreg     <= {sreg[8:0], 1'b0};
                  cnt      <= cnt - 4'd1;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  cnt   <= 4'd7;
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            CAPTURE: begin
               cap <= {cap[6:0], bus.MISO};
               if (cnt == 4'd0) begin
                  bus.rdata <= {cap[6:0], bus.MISO};
                  bus.SS_n  <= 1'b1;
                  bus.done  <= 1'b1;
                  cnt       <= GAP_TC;
                  state     <= GAP_ST;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            GAP_ST: begin
               if (cnt == 4'd0) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ram_ctrl.sv
// Scoreboard bench for spi_master_ram_ctrl. A serial RAM slave model answers the frames.
// Expected frames are queued at issue time and checked when done pulses.
module tb_spi_master_ram_ctrl;
   localparam int RD_LAT = 2;
   localparam int GAP    = 1;

   typedef struct {
      int          len;
      logic [10:0] mosi;
      logic [7:0]  rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_master_ram_ctrl_if bus ();

   spi_master_ram_ctrl #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t        q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  s_ram[256];
   logic [7:0]  s_addr = 8'h00;
   logic [7:0]  s_byte = 8'h00;
   logic        in_frame = 1'b0;
   logic        seen_frame = 1'b0;
   logic        chk_gap = 1'b0;
   int          idx = 0;
   int          last_len = 0;
   int          hi_run = 0;
   int          mosi_extra = 0;
   logic [10:0] mosi_acc = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Slave model and monitor: drives MISO and scores each completed frame.
   always @(negedge clk) begin
      if (rst) begin
         in_frame   = 1'b0;
         seen_frame = 1'b0;
         idx        = 0;
         hi_run     = 0;
         bus.MISO   = 1'b0;
      end else begin
         if (!bus.SS_n) begin
            if (!in_frame) begin
               if (seen_frame) begin
                  if (chk_gap) check("gap_exact", hi_run, GAP + 1);
                  else         check("gap_min", 32'(hi_run >= GAP), 1);
               end
               in_frame   = 1'b1;
               idx        = 0;
               mosi_acc   = '0;
               mosi_extra = 0;
            end
            if (idx < 11) mosi_acc = {mosi_acc[9:0], bus.MOSI};
            else if (bus.MOSI) mosi_extra++;
            if (idx == 10) begin
               case (mosi_acc[9:8])
                  2'b00, 2'b10: s_addr = mosi_acc[7:0];
                  2'b01:        s_ram[s_addr] = mosi_acc[7:0];
                  default:      s_byte = s_ram[s_addr];
               endcase
            end
            if (idx >= 11 + RD_LAT && idx < 19 + RD_LAT)
               bus.MISO = s_byte[7 - (idx - 11 - RD_LAT)];
            else
               bus.MISO = ~bus.MISO;
            idx++;
         end else begin
            if (in_frame) begin
               in_frame   = 1'b0;
               seen_frame = 1'b1;
               last_len   = idx;
               hi_run     = 0;
            end
            hi_run++;
            bus.MISO = ~bus.MISO;
         end
         if (bus.done) begin
            exp_t e;
            check("done_first_high", hi_run, 1);
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got done with empty queue, expected none");
            end else begin
               e = q.pop_front();
               check("frame_len", last_len, e.len);
               check("mosi_bits", {21'd0, mosi_acc}, {21'd0, e.mosi});
               check("mosi_idle_zero", mosi_extra, 0);
               check("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
            end
         end
      end
   end

   task automatic push(input logic [1:0] c, input logic [7:0] d, input logic [7:0] rd);
      exp_t e;
      e.len   = (c == 2'b11) ? 19 + RD_LAT : 11;
      e.mosi  = {c[1], c, d};
      e.rdata = rd;
      q.push_back(e);
   endtask

   task automatic kick(input logic [1:0] c, input logic [7:0] d);
      bus.start = 1'b1;
      bus.cmd   = c;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.cmd   = ~c;
      bus.wdata = ~d;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      if (i == 200) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: got busy after 200 cycles, expected idle");
      end
   endtask

   task automatic frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] rd);
      push(c, d, rd);
      kick(c, d);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nd;
      for (int i = 0; i < 256; i++) s_ram[i] = 8'h00;
      bus.start = 1'b0;
      bus.cmd   = 2'b00;
      bus.wdata = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ss_n", bus.SS_n, 1);
      check("rst_mosi", bus.MOSI, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_rdata", bus.rdata, 0);
      rst = 1'b0;
      @(negedge clk);

      frame(2'b00, 8'hA5, 8'h00);
      s_ram[8'hA5] = 8'h3C;
      frame(2'b11, 8'h00, 8'h3C);

      frame(2'b00, 8'h10, 8'h3C);
      frame(2'b01, 8'h7E, 8'h3C);
      frame(2'b10, 8'h10, 8'h3C);
      frame(2'b11, 8'h00, 8'h7E);

      frame(2'b00, 8'h20, 8'h7E);
      s_ram[8'h20] = 8'h81;
      frame(2'b11, 8'h5A, 8'h81);

      // start held high: three back-to-back write-data frames
      repeat (3) push(2'b01, 8'h55, 8'h81);
      bus.cmd   = 2'b01;
      bus.wdata = 8'h55;
      bus.start = 1'b1;
      nd = 0;
      for (int i = 0; i < 300 && nd < 3; i++) begin
         @(negedge clk);
         if (bus.done) begin
            nd++;
            if (nd == 1) chk_gap = 1'b1;
         end
      end
      bus.start = 1'b0;
      chk_gap   = 1'b0;
      check("held_frames", nd, 3);
      wait_idle();

      // reset in the middle of CAPTURE of a read returning FF
      s_ram[8'h20] = 8'hFF;
      kick(2'b11, 8'h00);
      repeat (16) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_ss_n", bus.SS_n, 1);
      check("abort_busy", bus.busy, 0);
      check("abort_rdata", bus.rdata, 0);
      check("abort_done", bus.done, 0);
      check("abort_mosi", bus.MOSI, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      frame(2'b10, 8'h33, 8'h00);
      s_ram[8'h33] = 8'hC3;
      frame(2'b11, 8'h00, 8'hC3);

      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
